// File: rtl/tl_error_responder.sv
// TileLink-UH error slave: accepts any request on A and answers it with a denied D
// response of the correct shape, one transaction at a time, with sticky status.
module tl_error_responder #(
  parameter int unsigned DATA_BYTES = 4,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned SOURCE_W   = 4,
  parameter int unsigned SIZE_W     = 3,
  parameter int unsigned MAX_SIZE   = 6
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    a_valid_i,
  output logic                    a_ready_o,
  input  logic [2:0]              a_opcode_i,
  input  logic [SIZE_W-1:0]       a_size_i,
  input  logic [SOURCE_W-1:0]     a_source_i,
  input  logic [ADDR_W-1:0]       a_address_i,
  output logic                    d_valid_o,
  input  logic                    d_ready_i,
  output logic [2:0]              d_opcode_o,
  output logic [SIZE_W-1:0]       d_size_o,
  output logic [SOURCE_W-1:0]     d_source_o,
  output logic                    d_denied_o,
  output logic                    d_corrupt_o,
  output logic [8*DATA_BYTES-1:0] d_data_o,
  output logic [15:0]             deny_count_o,
  output logic [ADDR_W-1:0]       last_addr_o
);

  localparam int unsigned LOG_DB = $clog2(DATA_BYTES);
  localparam int unsigned CNT_W  = MAX_SIZE - LOG_DB + 1;

  localparam logic [2:0] D_ACK      = 3'd0;
  localparam logic [2:0] D_ACK_DATA = 3'd1;
  localparam logic [2:0] D_HINT     = 3'd2;

  typedef enum logic [1:0] {IDLE, DRAIN, RESP} state_e;

  state_e              state_q;
  logic                a_ready_q;
  logic                d_valid_q;
  logic [2:0]          d_opcode_q;
  logic [SIZE_W-1:0]   d_size_q;
  logic [SOURCE_W-1:0] d_source_q;
  logic                d_corrupt_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    d_m1_q;
  logic [15:0]         deny_count_q;
  logic [ADDR_W-1:0]   last_addr_q;

  logic [CNT_W-1:0]    n_m1_c;
  logic [CNT_W-1:0]    a_m1_c;
  logic [CNT_W-1:0]    d_m1_c;
  logic [2:0]          d_op_c;

  // Beats minus one for a given size; sizes above MAX_SIZE count as MAX_SIZE.
  function automatic logic [CNT_W-1:0] beats_m1(input logic [SIZE_W-1:0] size);
    int unsigned eff;
    eff = (32'(size) > MAX_SIZE) ? MAX_SIZE : 32'(size);
    if (eff <= LOG_DB) return '0;
    return CNT_W'((32'd1 << (eff - LOG_DB)) - 32'd1);
  endfunction

  // Message shape of the request currently on A.
  always_comb begin
    n_m1_c = beats_m1(a_size_i);
    a_m1_c = '0;
    d_m1_c = '0;
    d_op_c = D_HINT;
    case (a_opcode_i)
      3'd0, 3'd1: begin
        a_m1_c = n_m1_c;
        d_op_c = D_ACK;
      end
      3'd2, 3'd3: begin
        a_m1_c = n_m1_c;
        d_m1_c = n_m1_c;
        d_op_c = D_ACK_DATA;
      end
      3'd4: begin
        d_m1_c = n_m1_c;
        d_op_c = D_ACK_DATA;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      a_ready_q    <= 1'b0;
      d_valid_q    <= 1'b0;
      d_opcode_q   <= '0;
      d_size_q     <= '0;
      d_source_q   <= '0;
      d_corrupt_q  <= 1'b0;
      cnt_q        <= '0;
      d_m1_q       <= '0;
      deny_count_q <= '0;
      last_addr_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          a_ready_q <= 1'b1;
          if (a_valid_i && a_ready_q) begin
            d_opcode_q  <= d_op_c;
            d_corrupt_q <= (d_op_c == D_ACK_DATA);
            d_size_q    <= a_size_i;
            d_source_q  <= a_source_i;
            d_m1_q      <= d_m1_c;
            last_addr_q <= a_address_i;
            if (a_m1_c != '0) begin
              state_q <= DRAIN;
              cnt_q   <= a_m1_c - CNT_W'(1);
            end else begin
              state_q   <= RESP;
              cnt_q     <= d_m1_c;
              a_ready_q <= 1'b0;
              d_valid_q <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (a_valid_i) begin
            if (cnt_q == '0) begin
              state_q   <= RESP;
              cnt_q     <= d_m1_q;
              a_ready_q <= 1'b0;
              d_valid_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
        end
        RESP: begin
          if (d_ready_i) begin
            if (cnt_q == '0) begin
              state_q   <= IDLE;
              a_ready_q <= 1'b1;
              d_valid_q <= 1'b0;
              if (deny_count_q != 16'hFFFF) deny_count_q <= deny_count_q + 16'd1;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a_ready_o    = a_ready_q;
  assign d_valid_o    = d_valid_q;
  assign d_opcode_o   = d_opcode_q;
  assign d_size_o     = d_size_q;
  assign d_source_o   = d_source_q;
  assign d_denied_o   = d_valid_q;
  assign d_corrupt_o  = d_corrupt_q;
  assign d_data_o     = '0;
  assign deny_count_o = deny_count_q;
  assign last_addr_o  = last_addr_q;

endmodule

// File: tb/tb_tl_error_responder.sv
// Directed, table-driven bench for tl_error_responder with a few hand-written
// sequences for reset-in-flight and counter saturation.
module tb_tl_error_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode;
  logic [2:0]  a_size;
  logic [3:0]  a_source;
  logic [31:0] a_address;
  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_opcode;
  logic [2:0]  d_size;
  logic [3:0]  d_source;
  logic        d_denied;
  logic        d_corrupt;
  logic [31:0] d_data;
  logic [15:0] deny_count;
  logic [31:0] last_addr;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [15:0] exp_deny = 16'd0;

  always #5 clk = ~clk;

  tl_error_responder dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .a_valid_i    (a_valid),
    .a_ready_o    (a_ready),
    .a_opcode_i   (a_opcode),
    .a_size_i     (a_size),
    .a_source_i   (a_source),
    .a_address_i  (a_address),
    .d_valid_o    (d_valid),
    .d_ready_i    (d_ready),
    .d_opcode_o   (d_opcode),
    .d_size_o     (d_size),
    .d_source_o   (d_source),
    .d_denied_o   (d_denied),
    .d_corrupt_o  (d_corrupt),
    .d_data_o     (d_data),
    .deny_count_o (deny_count),
    .last_addr_o  (last_addr)
  );

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  size;
    logic [3:0]  src;
    logic [31:0] addr;
    bit          toggle;
    int          stall;
    int          na;
    int          nd;
    logic [2:0]  dop;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one full request, consumes the response and checks its shape.
  task automatic do_txn(input vec_t v, input string tag);
    int  na, nd, cyc, lat, drain_bad, rsp_bad, fld_bad, stall;
    bit  ph, ardy;
    logic [2:0] f_op, f_sz;
    logic [3:0] f_src;
    na = 0; nd = 0; lat = 0; drain_bad = 0; rsp_bad = 0; fld_bad = 0;
    stall = v.stall; ph = 1'b1; cyc = 0;
    d_ready = (stall == 0);
    while (!d_valid && cyc < 400) begin
      if (na == 0) begin
        a_opcode = v.op; a_size = v.size; a_source = v.src; a_address = v.addr;
      end else begin
        a_opcode = 3'd4; a_size = 3'd0; a_source = ~v.src; a_address = ~v.addr;
      end
      a_valid = (na < v.na) && (v.toggle ? ph : 1'b1);
      ph = !ph;
      if (na > 0 && na < v.na && !a_ready) drain_bad++;
      if (na == v.na) lat++;
      ardy = a_ready;
      @(posedge clk);
      if (a_valid && ardy) na++;
      @(negedge clk);
      cyc++;
    end
    a_valid = 1'b0;
    check({tag, "_a_beats"}, 64'(na), 64'(v.na));
    check({tag, "_d_latency"}, 64'(lat), 64'd0);
    check({tag, "_a_ready_drain"}, 64'(drain_bad), 64'd0);
    check({tag, "_d_opcode"}, 64'(d_opcode), 64'(v.dop));
    check({tag, "_d_size"}, 64'(d_size), 64'(v.size));
    check({tag, "_d_source"}, 64'(d_source), 64'(v.src));
    check({tag, "_d_corrupt"}, 64'(d_corrupt), 64'(v.dop == 3'd1));
    check({tag, "_d_denied"}, 64'(d_denied), 64'd1);
    check({tag, "_d_data"}, 64'(d_data), 64'd0);
    f_op = d_opcode; f_sz = d_size; f_src = d_source;
    cyc = 0;
    while (d_valid && cyc < 400) begin
      d_ready = (stall == 0);
      if (d_opcode !== f_op || d_size !== f_sz || d_source !== f_src || d_denied !== 1'b1 ||
          d_corrupt !== (v.dop == 3'd1) || d_data !== 32'd0) fld_bad++;
      if (a_ready) rsp_bad++;
      if (stall > 0) stall--;
      @(posedge clk);
      if (d_valid && d_ready) nd++;
      @(negedge clk);
      cyc++;
    end
    d_ready = 1'b1;
    exp_deny = (exp_deny == 16'hFFFF) ? exp_deny : exp_deny + 16'd1;
    check({tag, "_d_beats"}, 64'(nd), 64'(v.nd));
    check({tag, "_d_fields_stable"}, 64'(fld_bad), 64'd0);
    check({tag, "_a_ready_in_resp"}, 64'(rsp_bad), 64'd0);
    check({tag, "_a_ready_after"}, 64'(a_ready), 64'd1);
    check({tag, "_deny_count"}, 64'(deny_count), 64'(exp_deny));
    check({tag, "_last_addr"}, 64'(last_addr), 64'(v.addr));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[11];
    vec_t g;
    int   hs, cyc;
    bit   ardy;

    //           op    size  src    addr           tgl stall na  nd  dop
    vecs[0]  = '{3'd4, 3'd4, 4'd3,  32'h2000_0010, 0,  0,    1,  4,  3'd1};
    vecs[1]  = '{3'd0, 3'd5, 4'd5,  32'h2000_0100, 1,  0,    8,  1,  3'd0};
    vecs[2]  = '{3'd5, 3'd2, 4'd1,  32'h2000_0200, 0,  0,    1,  1,  3'd2};
    vecs[3]  = '{3'd7, 3'd6, 4'd2,  32'h2000_0204, 0,  0,    1,  1,  3'd2};
    vecs[4]  = '{3'd4, 3'd3, 4'd6,  32'h2000_0300, 0,  5,    1,  2,  3'd1};
    vecs[5]  = '{3'd1, 3'd2, 4'd7,  32'h2000_0400, 0,  0,    1,  1,  3'd0};
    vecs[6]  = '{3'd3, 3'd4, 4'd8,  32'h2000_0500, 0,  0,    4,  4,  3'd1};
    vecs[7]  = '{3'd2, 3'd7, 4'd9,  32'h2000_0600, 0,  0,    16, 16, 3'd1};
    vecs[8]  = '{3'd4, 3'd0, 4'hA,  32'h2000_0700, 0,  0,    1,  1,  3'd1};
    vecs[9]  = '{3'd6, 3'd3, 4'hB,  32'h2000_0800, 0,  0,    1,  1,  3'd2};
    vecs[10] = '{3'd4, 3'd6, 4'hF,  32'h2000_0900, 1,  2,    1,  16, 3'd1};

    rst_n = 1'b0; a_valid = 1'b0; a_opcode = '0; a_size = '0; a_source = '0;
    a_address = '0; d_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_a_ready", 64'(a_ready), 64'd0);
    check("rst_d_valid", 64'(d_valid), 64'd0);
    check("rst_d_fields", 64'({d_opcode, d_size, d_source, d_corrupt, d_denied}), 64'd0);
    check("rst_deny_count", 64'(deny_count), 64'd0);
    check("rst_last_addr", 64'(last_addr), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rel_a_ready_before_edge", 64'(a_ready), 64'd0);
    @(negedge clk);
    check("rel_a_ready_after_edge", 64'(a_ready), 64'd1);

    for (int i = 0; i < 11; i++) do_txn(vecs[i], $sformatf("v%0d", i));

    // Reset while draining the third beat of an 8-beat Arithmetic.
    a_opcode = 3'd2; a_size = 3'd5; a_source = 4'd9; a_address = 32'h3000_0040;
    a_valid = 1'b1; hs = 0; cyc = 0;
    while (hs < 2 && cyc < 20) begin
      ardy = a_ready;
      @(posedge clk);
      if (ardy) hs++;
      @(negedge clk);
      cyc++;
    end
    check("mid_drain_beats", 64'(hs), 64'd2);
    rst_n = 1'b0;
    #1;
    exp_deny = 16'd0;
    check("mid_rst_a_ready", 64'(a_ready), 64'd0);
    check("mid_rst_d_valid", 64'(d_valid), 64'd0);
    check("mid_rst_deny_count", 64'(deny_count), 64'd0);
    check("mid_rst_last_addr", 64'(last_addr), 64'd0);
    a_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rel_a_ready", 64'(a_ready), 64'd1);
    g = '{3'd4, 3'd2, 4'd4, 32'h3000_0080, 0, 0, 1, 1, 3'd1};
    do_txn(g, "post_rst_get");

    // Saturation of the completion counter.
    force dut.deny_count_q = 16'hFFFE;
    @(negedge clk);
    release dut.deny_count_q;
    exp_deny = 16'hFFFE;
    @(negedge clk);
    check("sat_preload", 64'(deny_count), 64'hFFFE);
    g = '{3'd4, 3'd2, 4'd5, 32'h4000_0000, 0, 0, 1, 1, 3'd1};
    do_txn(g, "sat_to_max");
    g = '{3'd4, 3'd3, 4'd6, 32'h4000_0010, 0, 0, 1, 2, 3'd1};
    do_txn(g, "sat_hold");
    check("sat_final", 64'(deny_count), 64'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
